regfile_wb_arbiter: RTL

Arbitrates the single write port of the system register file among three writeback requesters: ALU, load unit and CSR unit. Uses round-robin grant with valid/ready handshakes. Registers the winning write into a one-stage output that drives the register file write enable, address and data. Also exposes operand-forwarding hits for the in-flight write and a saturating contention counter for debug.

---
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the three requesters (ALU, LSU, CSR) and the arbiter,
// plus the registered register-file write port the arbiter drives.
//   master : requester side (drives valid/rd_addr/data, observes ready and write port)
//   slave  : arbiter side (drives ready and the write port)
interface regfile_wb_arbiter_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
);
   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_rd_addr;
   logic [XLEN-1:0]       alu_data;
   logic                  alu_ready;

   logic                  lsu_valid;
   logic [REG_ADDR_W-1:0] lsu_rd_addr;
   logic [XLEN-1:0]       lsu_data;
   logic                  lsu_ready;

   logic                  csr_valid;
   logic [REG_ADDR_W-1:0] csr_rd_addr;
   logic [XLEN-1:0]       csr_data;
   logic                  csr_ready;

   logic                  wr_en;
   logic [REG_ADDR_W-1:0] wr_addr;
   logic [XLEN-1:0]       wr_data;

   modport master (
      output alu_valid, alu_rd_addr, alu_data,
      output lsu_valid, lsu_rd_addr, lsu_data,
      output csr_valid, csr_rd_addr, csr_data,
      input  alu_ready, lsu_ready, csr_ready,
      input  wr_en, wr_addr, wr_data
   );

   modport slave (
      input  alu_valid, alu_rd_addr, alu_data,
      input  lsu_valid, lsu_rd_addr, lsu_data,
      input  csr_valid, csr_rd_addr, csr_data,
      output alu_ready, lsu_ready, csr_ready,
      output wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   halt              blocks all grants and freezes the round-robin pointer
//   wb                writeback bus (requester handshakes + registered write port)
//   rs1/rs2_addr      operand read addresses
//   rs1/rs2_fwd_hit   in-flight write targets the operand (combinational)
//   contention_cnt    saturating count of contended cycles
module regfile_wb_arbiter #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  halt,
   regfile_wb_arbiter_if.slave   wb,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_fwd_hit,
   output logic                  rs2_fwd_hit,
   output logic [CNT_W-1:0]      contention_cnt
);

   localparam int unsigned NUM_REQ = 3;

   logic [1:0]            rr_ptr_q, rr_ptr_d;
   logic                  wr_en_q, wr_en_d;
   logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]       wr_data_q, wr_data_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [NUM_REQ-1:0]    req_vld;
   logic [1:0]            start_idx;
   logic [2:0]            scan_idx;
   logic                  gnt_found;
   logic [1:0]            gnt_idx;
   logic                  xfer;
   logic [REG_ADDR_W-1:0] sel_addr;
   logic [XLEN-1:0]       sel_data;
   logic                  multi_vld;
   logic                  contended;

   assign req_vld   = {wb.csr_valid, wb.lsu_valid, wb.alu_valid};
   // Illegal pointer value 3 behaves as ALU-first.
   assign start_idx = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;

   // First valid requester scanning from the pointer, wrapping modulo 3.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = 2'd0;
      scan_idx  = 3'd0;
      for (int k = 0; k < 3; k++) begin
         scan_idx = 3'(start_idx) + 3'(k);
         if (scan_idx >= 3'd3) scan_idx = scan_idx - 3'd3;
         if (!gnt_found && req_vld[scan_idx[1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_idx[1:0];
         end
      end
   end

   // Grant is suppressed by halt and held off entirely during reset.
   assign xfer = gnt_found & ~halt & rst_n;

   assign wb.alu_ready = xfer & (gnt_idx == 2'd0);
   assign wb.lsu_ready = xfer & (gnt_idx == 2'd1);
   assign wb.csr_ready = xfer & (gnt_idx == 2'd2);

   // Winning payload mux.
   always_comb begin
      sel_addr = wb.alu_rd_addr;
      sel_data = wb.alu_data;
      case (gnt_idx)
         2'd1:    begin sel_addr = wb.lsu_rd_addr; sel_data = wb.lsu_data; end
         2'd2:    begin sel_addr = wb.csr_rd_addr; sel_data = wb.csr_data; end
         default: begin sel_addr = wb.alu_rd_addr; sel_data = wb.alu_data; end
      endcase
   end

   assign multi_vld = (req_vld[0] & req_vld[1]) | (req_vld[0] & req_vld[2]) |
                      (req_vld[1] & req_vld[2]);
   assign contended = halt ? (|req_vld) : multi_vld;

   // Next-state: pointer, output stage and debug counter.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      cnt_d     = cnt_q;
      if (xfer) begin
         rr_ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
         // Writes to x0 are accepted but never reach the register file.
         if (sel_addr != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
         end
      end
      if (contended && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= 2'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         cnt_q     <= cnt_d;
      end
   end

   assign wb.wr_en        = wr_en_q;
   assign wb.wr_addr      = wr_addr_q;
   assign wb.wr_data      = wr_data_q;
   assign contention_cnt  = cnt_q;

   // Forwarding from the in-flight write; x0 never forwards.
   assign rs1_fwd_hit = wr_en_q & (wr_addr_q == rs1_addr) & (rs1_addr != '0);
   assign rs2_fwd_hit = wr_en_q & (wr_addr_q == rs2_addr) & (rs2_addr != '0);

endmodule
